// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
package mole_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PICK   = 3'd1,
        UP     = 3'd2,
        GAP    = 3'd3,
        PAUSED = 3'd4,
        OVER   = 3'd5
    } state_e;

    localparam int         NUM_OVALS = 5;
    localparam logic [2:0] OVAL_NONE = 3'd0;
    localparam int         SCORE_W   = 4;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used as the mole position source.
// Shifts left every cycle; feedback into bit 0 is b7^b5^b4^b3.
module mole_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next value: shift left with XOR feedback into bit 0.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR register, reloaded with the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: picks the mole oval, times the up/gap
// phases, scores whacks, and handles pause and game over.
// Optional build macro MOLE_MISS_PENALTY_EN: each expired mole also
// decrements the score (saturating at 0).
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int         UP_TICKS  = 8,
    parameter int         GAP_TICKS = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         SCORE_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic               pause_req,
    input  logic [4:0]         whack,
    input  logic               timer_done,
    output logic [2:0]         oval_select,
    output logic               enable,
    output logic               pause,
    output logic [SCORE_W-1:0] score,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over
);

    localparam int CNT_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]   UP_LAST   = CNT_W'(UP_TICKS - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_SAT = SCORE_W'(SCORE_MAX);

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         oval_q, oval_d;
    logic [2:0]         prev_q, prev_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               enable_q, enable_d;
    logic               pause_q, pause_d;
    logic               over_q, over_d;

    logic [7:0] lfsr;
    logic [7:0] rnd_mod;
    logic [2:0] cand;
    logic [4:0] oval_mask;
    logic       whack_hit;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    // Candidate oval 1..5 from the LFSR, bumped by one when it repeats the last mole.
    always_comb begin
        rnd_mod = lfsr % 8'(NUM_OVALS);
        cand    = rnd_mod[2:0] + 3'd1;
        if (cand == prev_q) begin
            cand = (cand == 3'd5) ? 3'd1 : cand + 3'd1;
        end
    end

    // One-hot mask of the active oval; whacks on any other bit are ignored.
    always_comb begin
        oval_mask = 5'b00000;
        case (oval_q)
            3'd1:    oval_mask = 5'b00001;
            3'd2:    oval_mask = 5'b00010;
            3'd3:    oval_mask = 5'b00100;
            3'd4:    oval_mask = 5'b01000;
            3'd5:    oval_mask = 5'b10000;
            default: oval_mask = 5'b00000;
        endcase
        whack_hit = |(whack & oval_mask);
    end

    // Next-state and registered-output logic. timer_done outranks everything
    // in a running game, then pause_req, then the per-state behaviour.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        oval_d  = oval_q;
        prev_d  = prev_q;
        score_d = score_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;

        if ((state_q inside {PICK, UP, GAP, PAUSED}) && timer_done) begin
            state_d = OVER;
            oval_d  = OVAL_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = PICK;
                        score_d = '0;
                    end
                end
                PICK, UP, GAP: begin
                    if (pause_req) begin
                        ret_d   = state_q;
                        state_d = PAUSED;
                    end else if (state_q == PICK) begin
                        oval_d  = cand;
                        prev_d  = cand;
                        cnt_d   = '0;
                        state_d = UP;
                    end else if (state_q == UP) begin
                        if (whack_hit) begin
                            score_d = (score_q >= SCORE_SAT) ? SCORE_SAT : score_q + 1'b1;
                            hit_d   = 1'b1;
                            oval_d  = OVAL_NONE;
                            cnt_d   = '0;
                            state_d = GAP;
                        end else if (tick) begin
                            if (cnt_q == UP_LAST) begin
                                miss_d  = 1'b1;
                                oval_d  = OVAL_NONE;
                                cnt_d   = '0;
                                state_d = GAP;
`ifdef MOLE_MISS_PENALTY_EN
                                score_d = (score_q == '0) ? '0 : score_q - 1'b1;
`endif
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end else begin
                        if (tick) begin
                            if (cnt_q == GAP_LAST) begin
                                cnt_d   = '0;
                                state_d = PICK;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (pause_req) state_d = ret_q;
                end
                OVER: begin
                    if (start) begin
                        state_d = PICK;
                        score_d = '0;
                        prev_d  = OVAL_NONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        enable_d = (state_d inside {PICK, UP, GAP, PAUSED});
        pause_d  = (state_d == PAUSED);
        over_d   = (state_d == OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ret_q    <= IDLE;
            cnt_q    <= '0;
            oval_q   <= OVAL_NONE;
            prev_q   <= OVAL_NONE;
            score_q  <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            enable_q <= 1'b0;
            pause_q  <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            cnt_q    <= cnt_d;
            oval_q   <= oval_d;
            prev_q   <= prev_d;
            score_q  <= score_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            enable_q <= enable_d;
            pause_q  <= pause_d;
            over_q   <= over_d;
        end
    end

    assign oval_select = oval_q;
    assign enable      = enable_q;
    assign pause       = pause_q;
    assign score       = score_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign game_over   = over_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl with UP_TICKS=4, GAP_TICKS=2.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_mole_game_ctrl;

    localparam int UP_T  = 4;
    localparam int GAP_T = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       start;
    logic       pause_req;
    logic [4:0] whack;
    logic       timer_done;
    logic [2:0] oval_select;
    logic       enable;
    logic       pause;
    logic [3:0] score;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       game_over;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mdl_q;
    logic [7:0] mdl_prev_q;
    logic [2:0] exp_prev;
    logic [2:0] cur;
    logic [3:0] exp_score;

    mole_game_ctrl #(
        .UP_TICKS  (UP_T),
        .GAP_TICKS (GAP_T),
        .LFSR_SEED (8'hA5),
        .SCORE_MAX (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .pause_req   (pause_req),
        .whack       (whack),
        .timer_done  (timer_done),
        .oval_select (oval_select),
        .enable      (enable),
        .pause       (pause),
        .score       (score),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .game_over   (game_over)
    );

    // Clock.
    always #5 clk = ~clk;

    // Reference LFSR; mdl_prev_q holds the value seen by the most recent edge.
    always @(posedge clk) begin
        if (rst) begin
            mdl_q      <= 8'hA5;
            mdl_prev_q <= 8'hA5;
        end else begin
            mdl_prev_q <= mdl_q;
            mdl_q      <= {mdl_q[6:0], mdl_q[7] ^ mdl_q[5] ^ mdl_q[4] ^ mdl_q[3]};
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2:0] exp_pick(input logic [7:0] r, input logic [2:0] p);
        int c;
        c = int'(r) % 5 + 1;
        if (c == int'(p)) c = (c % 5) + 1;
        return 3'(c);
    endfunction

    function automatic logic [4:0] onehot(input logic [2:0] o);
        logic [4:0] m;
        m = 5'b00001 << (o - 3'd1);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick1();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    // Called right after the edge that entered PICK.
    task automatic pick_step();
        chk("pick_enable", {7'd0, enable}, 8'd1);
        chk("pick_oval_none", {5'd0, oval_select}, 8'd0);
        cyc();
        cur = exp_pick(mdl_prev_q, exp_prev);
        chk("pick_oval", {5'd0, oval_select}, {5'd0, cur});
        chk("pick_differs", {7'd0, (oval_select != exp_prev)}, 8'd1);
        exp_prev = cur;
    endtask

    task automatic gap_then_pick();
        tick1();
        chk("gap_oval", {5'd0, oval_select}, 8'd0);
        idle(3);
        tick1();
        pick_step();
    endtask

    task automatic hit_round();
        whack = onehot(cur);
        cyc();
        whack = 5'd0;
        exp_score = (exp_score == 4'd15) ? 4'd15 : exp_score + 4'd1;
        chk("hit_pulse", {7'd0, hit_pulse}, 8'd1);
        chk("hit_score", {4'd0, score}, {4'd0, exp_score});
        chk("hit_oval", {5'd0, oval_select}, 8'd0);
        cyc();
        chk("hit_pulse_off", {7'd0, hit_pulse}, 8'd0);
        idle(2);
        gap_then_pick();
    endtask

    task automatic miss_round();
        whack = ~onehot(cur);
        cyc();
        whack = 5'd0;
        chk("wrong_whack_hit", {7'd0, hit_pulse}, 8'd0);
        chk("wrong_whack_oval", {5'd0, oval_select}, {5'd0, cur});
        for (int i = 0; i < UP_T - 1; i++) begin
            tick1();
            chk("miss_early", {7'd0, miss_pulse}, 8'd0);
            idle(3);
        end
        tick1();
`ifdef MOLE_MISS_PENALTY_EN
        exp_score = (exp_score == 4'd0) ? 4'd0 : exp_score - 4'd1;
`endif
        chk("miss_pulse", {7'd0, miss_pulse}, 8'd1);
        chk("miss_oval", {5'd0, oval_select}, 8'd0);
        chk("miss_score", {4'd0, score}, {4'd0, exp_score});
        cyc();
        chk("miss_pulse_off", {7'd0, miss_pulse}, 8'd0);
        idle(2);
        gap_then_pick();
    endtask

    initial begin
        rst        = 1'b1;
        tick       = 1'b0;
        start      = 1'b0;
        pause_req  = 1'b0;
        whack      = 5'd0;
        timer_done = 1'b0;
        exp_prev   = 3'd0;
        cur        = 3'd0;
        exp_score  = 4'd0;

        // Reset state.
        idle(3);
        rst = 1'b0;
        cyc();
        chk("rst_oval", {5'd0, oval_select}, 8'd0);
        chk("rst_enable", {7'd0, enable}, 8'd0);
        chk("rst_pause", {7'd0, pause}, 8'd0);
        chk("rst_score", {4'd0, score}, 8'd0);
        chk("rst_hit", {7'd0, hit_pulse}, 8'd0);
        chk("rst_miss", {7'd0, miss_pulse}, 8'd0);
        chk("rst_over", {7'd0, game_over}, 8'd0);

        // Start a game.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_score", {4'd0, score}, 8'd0);
        pick_step();

        // Miss at score 0, two hits, then a miss at score 2.
        miss_round();
        hit_round();
        hit_round();
        miss_round();

        // start while playing is ignored.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_ignored_oval", {5'd0, oval_select}, {5'd0, cur});
        chk("start_ignored_score", {4'd0, score}, {4'd0, exp_score});
        chk("start_ignored_enable", {7'd0, enable}, 8'd1);

        // Pause after two ticks of UP.
        tick1();
        idle(3);
        tick1();
        idle(1);
        pause_req = 1'b1;
        cyc();
        pause_req = 1'b0;
        chk("pause_on", {7'd0, pause}, 8'd1);
        chk("pause_enable", {7'd0, enable}, 8'd1);
        chk("pause_oval", {5'd0, oval_select}, {5'd0, cur});
        for (int i = 0; i < 20; i++) begin
            tick  = (i % 4 == 0);
            whack = onehot(cur);
            cyc();
            chk("paused_hit", {7'd0, hit_pulse}, 8'd0);
            chk("paused_miss", {7'd0, miss_pulse}, 8'd0);
        end
        tick  = 1'b0;
        whack = 5'd0;
        chk("paused_oval_held", {5'd0, oval_select}, {5'd0, cur});
        chk("paused_score_held", {4'd0, score}, {4'd0, exp_score});
        pause_req = 1'b1;
        cyc();
        pause_req = 1'b0;
        chk("resume_pause", {7'd0, pause}, 8'd0);
        chk("resume_oval", {5'd0, oval_select}, {5'd0, cur});
        idle(2);
        tick1();
        chk("resume_no_miss", {7'd0, miss_pulse}, 8'd0);
        idle(3);
        tick1();
`ifdef MOLE_MISS_PENALTY_EN
        exp_score = (exp_score == 4'd0) ? 4'd0 : exp_score - 4'd1;
`endif
        chk("resume_miss", {7'd0, miss_pulse}, 8'd1);
        chk("resume_miss_score", {4'd0, score}, {4'd0, exp_score});
        idle(3);
        gap_then_pick();

        // Sixteen hits saturate the score.
        for (int i = 0; i < 16; i++) begin
            hit_round();
        end
        chk("sat_score", {4'd0, score}, 8'd15);

        // timer_done with a correct whack in the same cycle.
        whack      = onehot(cur);
        timer_done = 1'b1;
        cyc();
        whack = 5'd0;
        chk("over_flag", {7'd0, game_over}, 8'd1);
        chk("over_enable", {7'd0, enable}, 8'd0);
        chk("over_oval", {5'd0, oval_select}, 8'd0);
        chk("over_no_hit", {7'd0, hit_pulse}, 8'd0);
        chk("over_score", {4'd0, score}, 8'd15);
        chk("over_pause", {7'd0, pause}, 8'd0);
        timer_done = 1'b0;
        pause_req  = 1'b1;
        cyc();
        pause_req = 1'b0;
        chk("over_pause_ignored", {7'd0, pause}, 8'd0);
        chk("over_held", {7'd0, game_over}, 8'd1);

        // Restart from OVER.
        start = 1'b1;
        cyc();
        start = 1'b0;
        exp_score = 4'd0;
        exp_prev  = 3'd0;
        chk("restart_score", {4'd0, score}, 8'd0);
        chk("restart_over", {7'd0, game_over}, 8'd0);
        pick_step();
        hit_round();

        // Reset mid-game.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_oval", {5'd0, oval_select}, 8'd0);
        chk("midrst_enable", {7'd0, enable}, 8'd0);
        chk("midrst_score", {4'd0, score}, 8'd0);
        chk("midrst_over", {7'd0, game_over}, 8'd0);
        pause_req = 1'b1;
        cyc();
        pause_req = 1'b0;
        chk("idle_pause_ignored", {7'd0, pause}, 8'd0);
        chk("idle_enable", {7'd0, enable}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
